// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 32-bit words written to instruction memory.
// Latency: one WRITE cycle follows the 4th byte of each word; cpu_hold drops the cycle after the last write.
// Backpressure: byte_ready is low during WRITE, DONE and ERR; bytes offered then are left in place upstream.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   byte_valid/_data  upstream byte stream, handshaken with byte_ready
//   im_we/_addr/_wdata instruction-memory write port (byte address, word aligned)
//   cpu_hold          1 holds the core in reset until the image is complete
//   reload            restart a load from DONE or ERR
//   load_done/_err    image complete / header length too large
//   words_loaded      words written in the current load
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  input  logic              reload,
  output logic              load_done,
  output logic              load_err,
  output logic [8:0]        words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [8:0]        word_idx_q, word_idx_d;
  // Holds the first three bytes of the word being assembled; the fourth
  // byte is merged straight into im_wdata on the way into WRITE.
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;

  logic              xfer;
  logic [15:0]       len_cand;
  logic [15:0]       next_word_cnt;

  assign byte_ready    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign xfer          = byte_valid && byte_ready;
  assign len_cand      = {len_q[15:8], byte_data};
  assign next_word_cnt = 16'(word_idx_q) + 16'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          state_d     = LEN_LO;
        end
      end

      LEN_LO: begin
        if (xfer) begin
          len_d      = len_cand;
          byte_idx_d = 2'd0;
          word_idx_d = 9'd0;
          if (len_cand == 16'd0) begin
            state_d = DONE;
          end else if (len_cand > MaxLen) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          if (byte_idx_q == 2'd3) begin
            // Address and data are registered here so they stay stable
            // after the write strobe drops.
            im_wdata_d = {shift_q, byte_data};
            im_addr_d  = ADDR_W'({word_idx_q, 2'b00});
            byte_idx_d = 2'd0;
            state_d    = WRITE;
          end else begin
            shift_d    = {shift_q[15:0], byte_data};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      WRITE: begin
        word_idx_d = word_idx_q + 9'd1;
        state_d    = (next_word_cnt == len_q) ? DONE : DATA;
      end

      DONE, ERR: begin
        if (reload) begin
          // Memory contents and the last write address/data are kept;
          // only the load bookkeeping restarts.
          state_d    = LEN_HI;
          byte_idx_d = 2'd0;
          word_idx_d = 9'd0;
          shift_d    = 24'd0;
        end
      end

      default: begin
        state_d = LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN_HI;
      len_q      <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= 9'd0;
      shift_q    <= 24'd0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  // All status outputs decode directly from the state register, so reset
  // drives them to their idle values without waiting for a clock.
  assign im_we        = (state_q == WRITE);
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = (state_q != DONE);
  assign load_done    = (state_q == DONE);
  assign load_err     = (state_q == ERR);
  assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              reload = 1'b0;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [8:0]        words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .reload       (reload),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted bytes and completed writes of the
  // current load; every expected output follows from those counts.
  int                m_acc = 0;
  int                m_len = 0;
  int                m_writes = 0;
  bit                m_wr = 1'b0;
  logic [7:0]        m_bytes [0:1023];
  logic [ADDR_W-1:0] m_last_addr = '0;
  logic [31:0]       m_last_data = 32'd0;

  // Log of what the DUT wrote, for the literal per-scenario checks.
  int                log_n = 0;
  logic [ADDR_W-1:0] log_addr [0:511];
  logic [31:0]       log_data [0:511];

  function automatic void model_new_load();
    m_acc    = 0;
    m_len    = 0;
    m_writes = 0;
    m_wr     = 1'b0;
  endfunction

  always @(negedge clk) begin : compare
    bit e_err, e_done, e_we, e_rdy;
    int w;
    if (!rst) begin
      model_new_load();
      m_last_addr = '0;
      m_last_data = 32'd0;
    end
    e_we   = m_wr;
    e_err  = (m_acc >= 2) && (m_len > MAX_WORDS);
    e_done = (m_acc >= 2) && !e_err && (m_writes == m_len) && !m_wr;
    e_rdy  = !e_we && !e_err && !e_done;
    if (e_we) begin
      w = m_writes;
      m_last_addr = ADDR_W'(w * 4);
      m_last_data = {m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]};
    end
    chk("byte_ready",   byte_ready,   e_rdy);
    chk("im_we",        im_we,        e_we);
    chk("cpu_hold",     cpu_hold,     !e_done);
    chk("load_done",    load_done,    e_done);
    chk("load_err",     load_err,     e_err);
    chk("words_loaded", words_loaded, m_writes);
    chk("im_addr",      im_addr,      m_last_addr);
    chk("im_wdata",     im_wdata,     m_last_data);
    if (im_we && log_n < 512) begin
      log_addr[log_n] = im_addr;
      log_data[log_n] = im_wdata;
      log_n++;
    end
    // Advance the model across the coming rising edge.
    if (rst) begin
      if (reload && (e_done || e_err)) begin
        model_new_load();
      end else if (e_we) begin
        m_writes++;
        m_wr = 1'b0;
      end else if (byte_valid && e_rdy) begin
        m_acc++;
        if (m_acc == 1) begin
          m_len = int'(byte_data) * 256;
        end else if (m_acc == 2) begin
          m_len = m_len + int'(byte_data);
        end else if (m_acc - 3 < 1024) begin
          m_bytes[m_acc-3] = byte_data;
          if ((m_acc - 2) % 4 == 0) m_wr = 1'b1;
        end
      end
    end
  end

  logic [7:0] stream [$];

  // Offers stream bytes with random gaps (gap = percent of idle cycles),
  // sprinkling reload pulses that must be ignored mid-load. Stops after
  // maxb accepted bytes. Entered and left just after a rising edge.
  task automatic send(input int gap, input int maxb);
    int idx = 0;
    int cyc = 0;
    bit fire;
    while (idx < stream.size() && idx < maxb && cyc < 6000) begin
      byte_valid = ($urandom_range(99) >= gap);
      byte_data  = byte_valid ? stream[idx] : 8'($urandom);
      reload     = ($urandom_range(31) == 0);
      @(negedge clk);
      #1;
      fire = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (fire) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    reload     = 1'b0;
    chk("send_complete", cyc < 6000, 1'b1);
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(load_done || load_err) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("wait_end", c < 2000, 1'b1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    int len;
    logic [31:0] wv;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_hold",  cpu_hold,     1'b1);
    chk("rst_im_we",     im_we,        1'b0);
    chk("rst_im_addr",   im_addr,      32'd0);
    chk("rst_im_wdata",  im_wdata,     32'd0);
    chk("rst_load_done", load_done,    1'b0);
    chk("rst_load_err",  load_err,     1'b0);
    chk("rst_words",     words_loaded, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Two-word image, continuous valid (bytes offered during WRITE too).
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    log_n = 0;
    send(0, 100000);
    wait_end();
    chk("a_we_count",  log_n,        32'd2);
    chk("a_addr0",     log_addr[0],  32'h0);
    chk("a_data0",     log_data[0],  32'h12345678);
    chk("a_addr1",     log_addr[1],  32'h4);
    chk("a_data1",     log_data[1],  32'h9ABCDEF0);
    chk("a_words",     words_loaded, 32'd2);
    chk("a_cpu_hold",  cpu_hold,     1'b0);
    chk("a_load_done", load_done,    1'b1);
    pulse_reload();

    // Zero-length image.
    stream = '{8'h00, 8'h00};
    log_n = 0;
    send(0, 100000);
    wait_end();
    chk("b_we_count", log_n,     32'd0);
    chk("b_cpu_hold", cpu_hold,  1'b0);
    chk("b_done",     load_done, 1'b1);
    pulse_reload();

    // Length 257 is one too many.
    stream = '{8'h01, 8'h01};
    log_n = 0;
    send(0, 100000);
    wait_end();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("c_err",      load_err,   1'b1);
    chk("c_cpu_hold", cpu_hold,   1'b1);
    chk("c_ready",    byte_ready, 1'b0);
    chk("c_we_count", log_n,      32'd0);
    pulse_reload();
    chk("c_reload_err",   load_err,   1'b0);
    chk("c_reload_ready", byte_ready, 1'b1);

    // Same two-word image with heavy random gaps.
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    log_n = 0;
    send(50, 100000);
    wait_end();
    chk("d_we_count", log_n,       32'd2);
    chk("d_data0",    log_data[0], 32'h12345678);
    chk("d_data1",    log_data[1], 32'h9ABCDEF0);
    chk("d_addr1",    log_addr[1], 32'h4);
    pulse_reload();

    // Reset after three bytes of the second word.
    stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    log_n = 0;
    send(0, 9);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("e_rst_cpu_hold", cpu_hold,     1'b1);
    chk("e_rst_im_we",    im_we,        1'b0);
    chk("e_rst_im_addr",  im_addr,      32'd0);
    chk("e_rst_im_wdata", im_wdata,     32'd0);
    chk("e_rst_words",    words_loaded, 32'd0);
    chk("e_rst_done",     load_done,    1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    log_n = 0;
    send(30, 100000);
    wait_end();
    chk("e_we_count", log_n,        32'd1);
    chk("e_addr0",    log_addr[0],  32'h0);
    chk("e_data0",    log_data[0],  32'hAABBCCDD);
    chk("e_words",    words_loaded, 32'd1);
    pulse_reload();

    // Largest image: 256 incrementing words.
    stream = '{8'h01, 8'h00};
    for (int i = 0; i < MAX_WORDS; i++) begin
      wv = 32'h1000_0000 + 32'(i);
      stream.push_back(wv[31:24]);
      stream.push_back(wv[23:16]);
      stream.push_back(wv[15:8]);
      stream.push_back(wv[7:0]);
    end
    log_n = 0;
    send(20, 100000);
    wait_end();
    chk("f_we_count",  log_n,         32'd256);
    chk("f_last_addr", log_addr[255], 32'h3FC);
    chk("f_last_data", log_data[255], 32'h100000FF);
    chk("f_words",     words_loaded,  32'd256);
    chk("f_done",      load_done,     1'b1);
    pulse_reload();

    // Random images, including empty and oversized headers.
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(7))
        0:       len = 0;
        1:       len = MAX_WORDS + 1 + int'($urandom_range(200));
        default: len = int'($urandom_range(12, 1));
      endcase
      stream = '{8'(len >> 8), 8'(len)};
      if (len <= MAX_WORDS) begin
        for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
      end
      log_n = 0;
      send(int'($urandom_range(60)), 100000);
      wait_end();
      chk("g_err",      load_err, (len > MAX_WORDS));
      chk("g_we_count", log_n,    (len > MAX_WORDS) ? 0 : len);
      pulse_reload();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of instruction memory (1 KiB).
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted image in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_valid  input  1  upstream byte-stream data valid.
REQ-006 SHALL have port byte_data  input  8  upstream byte.
REQ-007 SHALL have port byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr  output  ADDR_W  instruction-memory byte address, word-aligned.
REQ-010 SHALL have port im_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port cpu_hold  output  1  1 = processor core held in reset.
REQ-012 SHALL have port reload  input  1  request a new image load.
REQ-013 SHALL have port load_done  output  1  image fully written; core released.
REQ-014 SHALL have port load_err  output  1  header length exceeded MAX_WORDS.
REQ-015 SHALL have port words_loaded  output  9  count of words written in current load.

Function
REQ-016 SHALL transfer a byte only on a clk edge where byte_valid=1 and byte_ready=1; bytes presented while byte_ready=0 SHALL NOT be consumed.
REQ-017 SHALL implement states LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR; byte_ready=1 only in LEN_HI, LEN_LO, DATA.
REQ-018 LEN_HI: accepted byte -> len[15:8], go LEN_LO.
REQ-019 LEN_LO: accepted byte -> len[7:0]; next state DONE if len=0, ERR if len>MAX_WORDS, else DATA with byte index 0 and word index 0.
REQ-020 DATA: bytes assembled big-endian (first byte to [31:24], fourth to [7:0]); the 4th accepted byte SHALL move to WRITE.
REQ-021 WRITE: exactly one cycle with im_we=1, im_addr=word_index*4, im_wdata=assembled word; then word_index and words_loaded increment; next state DONE if new word_index equals len, else DATA.
REQ-022 im_we SHALL be 0 in every state other than WRITE; im_addr and im_wdata SHALL hold their last values when im_we=0.
REQ-023 cpu_hold SHALL be 1 in all states except DONE; in DONE cpu_hold=0 and load_done=1.
REQ-024 ERR: load_err=1, cpu_hold=1, no memory writes, byte stream not consumed.
REQ-025 reload=1 in DONE or ERR SHALL on the next edge go to LEN_HI with cpu_hold=1, load_done=0, load_err=0, words_loaded=0, indices 0; reload in any other state SHALL be ignored.
REQ-026 Lengths 1..MAX_WORDS SHALL be accepted; len=MAX_WORDS writes last word at address (MAX_WORDS-1)*4 without wrap.
REQ-027 Instruction-memory contents SHALL never be cleared by the loader; partially received words SHALL be discarded on reset or reload.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force state LEN_HI, cpu_hold=1, im_we=0, im_addr=0, im_wdata=0, load_done=0, load_err=0, words_loaded=0, byte/word indices 0.
REQ-029 Reset asserted mid-load SHALL abandon the load; after rst=1 the next accepted byte is treated as LEN_HI.
REQ-030 Core release SHALL occur only via DONE; no output SHALL depend on reset deassertion timing other than returning to LEN_HI.

Verification
REQ-031 Stream 00 02 12 34 56 78 9A BC DE F0 -> writes 0x12345678 @0, 0x9ABCDEF0 @4; im_we high exactly 2 cycles; then cpu_hold=0, load_done=1, words_loaded=2.
REQ-032 Stream 00 00 -> DONE directly, no im_we pulse, cpu_hold=0 two accepted bytes after reset.
REQ-033 Stream 01 01 (257) -> load_err=1, cpu_hold=1, no writes, byte_ready=0; reload -> LEN_HI, load_err=0.
REQ-034 byte_valid toggled randomly with gaps and bytes offered during WRITE -> same memory image as REQ-031; no byte lost or duplicated.
REQ-035 rst pulsed low after 3 data bytes of word 1 -> outputs at reset values at once; fresh stream 00 01 AA BB CC DD writes 0xAABBCCDD @0 only.
REQ-036 len=256 with incrementing words -> last write at address 0x3FC, words_loaded=256, then DONE.
